hilo_mac_sequencer: RTL and testbench

Multi-cycle multiply / multiply-accumulate engine that owns the architectural HI/LO register pair and sequences the MUL, MULU, MADD and MADDU operations of the single-cycle core. The core sees a stall/done handshake: it holds the instruction and asserts `start` until `done`. The single-cycle ALU keeps all other R-type and FPU operations. This engine replaces combinational 32x32 product logic with a radix-2 shift-add loop.

---
 rtl/hilo_mac_sequencer_pkg.sv | 30 +++
 rtl/hilo_mac_sequencer_if.sv | 28 ++
 rtl/hilo_mac_sequencer_core.sv | 57 +++++
 rtl/hilo_mac_sequencer.sv | 109 ++++++++++
 tb/tb_hilo_mac_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hilo_mac_sequencer_pkg.sv
// Shared types and constants for the HI/LO multiply / multiply-accumulate engine.
package hilo_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MADD  = 2'b01,
        MADDU = 2'b10,
        MULU  = 2'b11
    } mac_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } mac_state_e;

    function automatic logic is_signed_op(mac_op_e op);
        return (op == MUL) || (op == MADD);
    endfunction

    // The most negative value maps onto itself, which is correct when read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_mac_sequencer_if.sv
// Request/response bundle between the core (master) and the HI/LO engine (slave).
interface hilo_mac_sequencer_if;
    import hilo_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;
    logic            stall;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/hilo_mac_sequencer_core.sv
// Radix-2 shift-add unsigned multiplier datapath; one partial-product step per cycle.
module shift_add_mul_core
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [XLEN-1:0]   mcand_in,
    input  logic [XLEN-1:0]   mplier_in,
    output logic [2*XLEN-1:0] partial,
    output logic              last
);

    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{XLEN{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign partial = prod_q;
    assign last    = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/hilo_mac_sequencer.sv
// Sequences MUL/MULU/MADD/MADDU over the shift-add core and owns the architectural HI/LO pair.
module hilo_mac_sequencer
    import hilo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hilo_mac_sequencer_if.slave  bus
);

    mac_state_e      state_q, state_d;
    mac_op_e         op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    mac_op_e           op_in;
    logic              accept;
    logic [XLEN-1:0]   mcand_in;
    logic [XLEN-1:0]   mplier_in;
    logic [2*XLEN-1:0] partial;
    logic [2*XLEN-1:0] product;
    logic              last;

    assign op_in     = mac_op_e'(bus.op);
    assign accept    = (state_q == IDLE) && bus.start;
    assign mcand_in  = is_signed_op(op_in) ? magnitude(bus.a) : bus.a;
    assign mplier_in = is_signed_op(op_in) ? magnitude(bus.b) : bus.b;
    assign product   = neg_q ? (~partial + 1'b1) : partial;

    shift_add_mul_core u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == RUN),
        .mcand_in  (mcand_in),
        .mplier_in (mplier_in),
        .partial   (partial),
        .last      (last)
    );

    // Direct HI/LO writes only land in a quiet IDLE cycle; a pending start wins.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    op_d    = op_in;
                    neg_d   = is_signed_op(op_in) & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                if (last) state_d = FIX;
            end
            FIX: begin
                if ((op_q == MUL) || (op_q == MULU)) begin
                    {hi_d, lo_d} = product;
                end else begin
                    {hi_d, lo_d} = {hi_q, lo_q} + product;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = bus.start & ~done_q;

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
// Directed bench for hilo_mac_sequencer: hand-computed products, timing, reset abort and dropped writes.
module tb_hilo_mac_sequencer;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hilo_mac_sequencer_if bus ();

    hilo_mac_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic hwe, input logic lwe,
                                 input logic [31:0] wd);
        bus.start = s;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = hwe;
        bus.lo_we = lwe;
        bus.wdata = wd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic directWrite(input logic hwe, input logic lwe, input logic [31:0] wd);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, hwe, lwe, wd);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Runs one operation from an IDLE cycle (cycle 0) and checks the 34-cycle stall, the
    // single done pulse, HI/LO holding through RUN and the final HI/LO value.
    task automatic runOp(input string tag, input mac_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic hiWeAtStart, input logic loWeInRun,
                         input logic [63:0] expHiLo);
        logic [63:0] startHiLo;
        logic [63:0] resHiLo;
        int          doneCyc;
        int          stallBad;
        startHiLo = {bus.hi, bus.lo};
        resHiLo   = '0;
        doneCyc   = -1;
        stallBad  = 0;
        applyStimulus(1'b1, op, a, b, hiWeAtStart, 1'b0, 32'hAAAA5555);
        for (int cyc = 0; cyc < 100 && doneCyc < 0; cyc++) begin
            @(negedge clk);
            if (bus.stall !== (cyc < 34)) stallBad++;
            if (cyc == 20) checkOutput({tag, "_hold"}, {bus.hi, bus.lo}, startHiLo);
            if (bus.done === 1'b1) begin
                doneCyc = cyc;
                resHiLo = {bus.hi, bus.lo};
            end
            nextCycle();
            bus.hi_we = 1'b0;
            bus.lo_we = loWeInRun && (cyc == 4);
        end
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_done_cycle"}, 64'(doneCyc), 64'd34);
        checkOutput({tag, "_stall"}, 64'(stallBad), 64'd0);
        checkOutput({tag, "_hilo"}, resHiLo, expHiLo);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int pulses;
        int firstCyc;
        int secondCyc;
        logic [31:0] lo1;
        logic [31:0] lo2;

        // Reset state, with stall following start while held in reset.
        rst = 1'b1;
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        checkOutput("rst_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
        checkOutput("rst_stall_hi", 64'(bus.stall), 64'd1);
        bus.start = 1'b0;
        #1;
        checkOutput("rst_stall_lo", 64'(bus.stall), 64'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("[TB] MUL -3 * 7");
        runOp("mul_neg", MUL, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFEB);

        $display("[TB] MADDU carry into HI");
        directWrite(1'b1, 1'b0, 32'h0);
        directWrite(1'b0, 1'b1, 32'hFFFFFFFF);
        checkOutput("preset_hilo", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
        runOp("maddu_carry", MADDU, 32'd1, 32'd1, 1'b0, 1'b0, 64'h00000001_00000000);

        $display("[TB] MADD / MUL with most negative operands");
        directWrite(1'b1, 1'b1, 32'h0);
        runOp("madd_min", MADD, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h40000000_00000000);
        directWrite(1'b1, 1'b1, 32'd5);
        checkOutput("preset_five", {bus.hi, bus.lo}, 64'h00000005_00000005);
        runOp("mul_min", MUL, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h40000000_00000000);

        // Abort mid-RUN: reset sampled at the end of cycle 10.
        $display("[TB] reset during RUN");
        applyStimulus(1'b1, MADD, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0);
        repeat (10) nextCycle();
        @(negedge clk);
        checkOutput("abort_busy_before", 64'(bus.busy), 64'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        pulses = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        checkOutput("abort_no_done", 64'(pulses), 64'd0);
        nextCycle();
        runOp("mulu_max", MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001);

        // Held start: two operations, done in cycles 34 and 69.
        $display("[TB] back-to-back MADD with start held");
        directWrite(1'b1, 1'b1, 32'h0);
        applyStimulus(1'b1, MADD, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0);
        pulses    = 0;
        firstCyc  = -1;
        secondCyc = -1;
        lo1       = '0;
        lo2       = '0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    firstCyc = cyc;
                    lo1      = bus.lo;
                end else begin
                    secondCyc = cyc;
                    lo2       = bus.lo;
                end
            end
            nextCycle();
        end
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        checkOutput("b2b_pulses", 64'(pulses), 64'd2);
        checkOutput("b2b_first_cycle", 64'(firstCyc), 64'd34);
        checkOutput("b2b_second_cycle", 64'(secondCyc), 64'd69);
        checkOutput("b2b_lo_first", 64'(lo1), 64'd6);
        checkOutput("b2b_lo_second", 64'(lo2), 64'd12);
        checkOutput("b2b_hi", 64'(bus.hi), 64'd0);

        // hi_we alongside start and lo_we during RUN must both be dropped; 0*0 leaves HI/LO alone.
        $display("[TB] dropped direct writes");
        nextCycle();
        runOp("drop", MADDU, 32'd0, 32'd0, 1'b1, 1'b1, 64'h00000000_0000000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
